// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and types for the MIDI note parser.
// Latency: n/a (package only). Backpressure: n/a.
// Contents: status nibble codes, real-time threshold, parser state and byte-class enums.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;

  // Bytes at or above this value are real-time messages.
  localparam logic [7:0] RT_THRESH  = 8'hF8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    SKIP1,
    SKIP2
  } state_e;

  typedef enum logic [1:0] {
    BYTE_DATA,
    BYTE_VOICE,
    BYTE_SYS,
    BYTE_RT
  } byte_class_e;

endpackage

// File: rtl/midi_parser_if.sv
// midi_parser_if: byte input strobe and note-event outputs of the MIDI parser.
// Latency: n/a (wiring only). Backpressure: none, bytes are accepted every strobe.
// Ports: dataReady_i/midiData_i toward the parser; note_o/velocity_o/gate_o/noteValid_o back.
interface midi_parser_if;

  logic       dataReady_i;
  logic [7:0] midiData_i;
  logic [6:0] note_o;
  logic [6:0] velocity_o;
  logic       gate_o;
  logic       noteValid_o;

  // master: the UART side feeding bytes and observing note events
  modport master (
    output dataReady_i, midiData_i,
    input  note_o, velocity_o, gate_o, noteValid_o
  );

  // slave: the parser itself
  modport slave (
    input  dataReady_i, midiData_i,
    output note_o, velocity_o, gate_o, noteValid_o
  );

endinterface

// File: rtl/midi_parser.sv
// midi_parser: MIDI byte stream to monophonic note/velocity/gate with one-cycle event strobe.
// Latency: 1 clk from the final data byte strobe to updated outputs and noteValid_o.
// Backpressure: none; one byte per cycle accepted, no stall.
// Ports: clk_i, rst_i (async active-high), bus (midi_parser_if.slave).
// Option: define MIDI_RUNNING_STATUS_EN to keep the status after a completed/skipped message.
module midi_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  midi_parser_if.slave bus
);

  function automatic byte_class_e classify(input logic [7:0] b);
    if (!b[7])                  return BYTE_DATA;
    else if (b >= RT_THRESH)    return BYTE_RT;
    else if (b[7:4] == 4'hF)    return BYTE_SYS;
    else                        return BYTE_VOICE;
  endfunction

  state_e     state_q, state_d;
  logic       is_on_q, is_on_d;        // latched status: 1 = Note On, 0 = Note Off
  logic       skip_two_q, skip_two_d;  // skipped status carries two data bytes
  logic [6:0] key_q, key_d;            // first data byte of the pending note message
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       valid_q, valid_d;

  byte_class_e cls;
  logic [3:0]  hi_nib;
  logic [3:0]  lo_nib;
  logic [6:0]  dat7;

  assign cls    = classify(bus.midiData_i);
  assign hi_nib = bus.midiData_i[7:4];
  assign lo_nib = bus.midiData_i[3:0];
  assign dat7   = bus.midiData_i[6:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      is_on_q    <= 1'b0;
      skip_two_q <= 1'b0;
      key_q      <= '0;
      note_q     <= '0;
      vel_q      <= '0;
      gate_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_on_q    <= is_on_d;
      skip_two_q <= skip_two_d;
      key_q      <= key_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      gate_q     <= gate_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_on_d    = is_on_q;
    skip_two_d = skip_two_q;
    key_d      = key_q;
    note_d     = note_q;
    vel_d      = vel_q;
    gate_d     = gate_q;
    valid_d    = 1'b0;

    if (bus.dataReady_i) begin
      unique case (cls)
        // Real-time bytes are transparent, even in the middle of a message.
        BYTE_RT: ;

        BYTE_SYS: begin
          state_d = IDLE;
          is_on_d = 1'b0;
        end

        BYTE_VOICE: begin
          if ((hi_nib == NOTE_ON || hi_nib == NOTE_OFF) && lo_nib == CHANNEL) begin
            is_on_d = (hi_nib == NOTE_ON);
            state_d = WAIT_D1;
          end else begin
            is_on_d    = 1'b0;
            skip_two_d = !(hi_nib == PROG_CHG || hi_nib == CHAN_PRESS);
            state_d    = skip_two_d ? SKIP2 : SKIP1;
          end
        end

        BYTE_DATA: begin
          unique case (state_q)
            IDLE: ;
            WAIT_D1: begin
              key_d   = dat7;
              state_d = WAIT_D2;
            end
            WAIT_D2: begin
              // Last-note priority: any Note On takes over; a release only
              // counts when it names the note currently sounding.
              if (is_on_q && dat7 != 7'd0) begin
                note_d  = key_q;
                vel_d   = dat7;
                gate_d  = 1'b1;
                valid_d = 1'b1;
              end else if (key_q == note_q && gate_q) begin
                gate_d  = 1'b0;
                valid_d = 1'b1;
              end
`ifdef MIDI_RUNNING_STATUS_EN
              state_d = WAIT_D1;
`else
              state_d = IDLE;
              is_on_d = 1'b0;
`endif
            end
            SKIP2: state_d = SKIP1;
            SKIP1: begin
`ifdef MIDI_RUNNING_STATUS_EN
              state_d = skip_two_q ? SKIP2 : SKIP1;
`else
              state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
          endcase
        end

        default: ;
      endcase
    end
  end

  assign bus.note_o      = note_q;
  assign bus.velocity_o  = vel_q;
  assign bus.gate_o      = gate_q;
  assign bus.noteValid_o = valid_q;

endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser: directed test-plan steps plus random byte stream against a message-level model.
// Latency: outputs compared 1 ns after each consuming clock edge.
// Backpressure: none; bytes are driven back-to-back on consecutive cycles.
module tb_midi_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  midi_parser_if bus ();

  midi_parser #(.CHANNEL(4'd0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Message-level reference: current running status plus collected data bytes.
  bit         have_st;
  logic [7:0] cur_st;
  logic [6:0] dbuf[$];
  logic [6:0] m_note, m_vel;
  logic       m_gate, m_pulse;

  function automatic void model_reset();
    have_st = 0;
    cur_st  = 8'h00;
    dbuf.delete();
    m_note  = 0;
    m_vel   = 0;
    m_gate  = 0;
    m_pulse = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int need;
    m_pulse = 0;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      have_st = 0;
      dbuf.delete();
      return;
    end
    if (b >= 8'h80) begin
      have_st = 1;
      cur_st  = b;
      dbuf.delete();
      return;
    end
    if (!have_st) return;
    dbuf.push_back(b[6:0]);
    need = (cur_st[7:4] == 4'hC || cur_st[7:4] == 4'hD) ? 1 : 2;
    if (dbuf.size() == need) begin
      if (cur_st[3:0] == 4'd0 && (cur_st[7:4] == 4'h8 || cur_st[7:4] == 4'h9)) begin
        if (cur_st[7:4] == 4'h9 && dbuf[1] != 0) begin
          m_note  = dbuf[0];
          m_vel   = dbuf[1];
          m_gate  = 1;
          m_pulse = 1;
        end else if (dbuf[0] == m_note && m_gate) begin
          m_gate  = 0;
          m_pulse = 1;
        end
      end
      dbuf.delete();
`ifndef MIDI_RUNNING_STATUS_EN
      have_st = 0;
`endif
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".note"},  32'(bus.note_o),      32'(m_note));
    chk({tag, ".vel"},   32'(bus.velocity_o),  32'(m_vel));
    chk({tag, ".gate"},  32'(bus.gate_o),      32'(m_gate));
    chk({tag, ".valid"}, 32'(bus.noteValid_o), 32'(m_pulse));
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    @(negedge clk);
    bus.dataReady_i = 1'b1;
    bus.midiData_i  = b;
    model_byte(b);
    @(posedge clk);
    #1;
    bus.dataReady_i = 1'b0;
    check_outs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.dataReady_i = 1'b0;
      m_pulse = 0;
      @(posedge clk);
      #1;
      check_outs(tag);
    end
  endtask

  logic [7:0] st_tab[12];

  initial begin
    bus.dataReady_i = 1'b0;
    bus.midiData_i  = 8'h00;
    model_reset();
    st_tab[0] = 8'h90; st_tab[1]  = 8'h80; st_tab[2]  = 8'h91; st_tab[3]  = 8'h81;
    st_tab[4] = 8'hC0; st_tab[5]  = 8'hD3; st_tab[6]  = 8'hB0; st_tab[7]  = 8'hE0;
    st_tab[8] = 8'hF0; st_tab[9]  = 8'hF8; st_tab[10] = 8'hFE; st_tab[11] = 8'h90;

    // Reset state
    #2;
    check_outs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Note On ch1, middle C velocity 100
    send(8'h90, "on.s"); send(8'h3C, "on.d1"); send(8'h64, "on.d2");
    chk("tp1.note",  32'(bus.note_o),      32'd60);
    chk("tp1.vel",   32'(bus.velocity_o),  32'd100);
    chk("tp1.gate",  32'(bus.gate_o),      32'd1);
    chk("tp1.valid", 32'(bus.noteValid_o), 32'd1);
    idle(1, "tp1.after");

    // Note Off, then Note On vel 0 while gate already low
    send(8'h80, "off.s"); send(8'h3C, "off.d1"); send(8'h40, "off.d2");
    chk("tp2.gate", 32'(bus.gate_o), 32'd0);
    chk("tp2.note", 32'(bus.note_o), 32'd60);
    send(8'h90, "on0.s"); send(8'h3C, "on0.d1"); send(8'h00, "on0.d2");
    chk("tp2.nostrobe", 32'(bus.noteValid_o), 32'd0);

    // Last-note priority with stale release
    send(8'h90, "lp.s1"); send(8'h3C, "lp.a"); send(8'h64, "lp.b");
    send(8'h90, "lp.s2"); send(8'h40, "lp.c"); send(8'h50, "lp.d");
    send(8'h80, "lp.s3"); send(8'h3C, "lp.e"); send(8'h00, "lp.f");
    chk("tp3.note", 32'(bus.note_o), 32'd64);
    chk("tp3.gate", 32'(bus.gate_o), 32'd1);
    idle(1, "tp3.after");

    // Real-time byte inside a message
    send(8'h90, "rt.s"); send(8'h3C, "rt.d1"); send(8'hF8, "rt.rt"); send(8'h64, "rt.d2");
    chk("tp4.note",  32'(bus.note_o),      32'd60);
    chk("tp4.valid", 32'(bus.noteValid_o), 32'd1);

    // Other channel, program change, control change: all ignored
    send(8'h91, "oc.s"); send(8'h3C, "oc.d1"); send(8'h64, "oc.d2");
    send(8'hC0, "pc.s"); send(8'h05, "pc.d1");
    send(8'hB0, "cc.s"); send(8'h07, "cc.d1"); send(8'h7F, "cc.d2");
    chk("tp5.note", 32'(bus.note_o), 32'd60);
    chk("tp5.vel",  32'(bus.velocity_o), 32'd100);

    // Running status pair
    send(8'h90, "rs.s"); send(8'h3C, "rs.a"); send(8'h64, "rs.b");
    send(8'h3E, "rs.c"); send(8'h50, "rs.d");
`ifdef MIDI_RUNNING_STATUS_EN
    chk("tp6.note", 32'(bus.note_o), 32'd62);
`else
    chk("tp6.note", 32'(bus.note_o), 32'd60);
`endif
    idle(1, "tp6.after");

    // Reset in the middle of a message; strobe during reset ignored
    send(8'h90, "mr.s"); send(8'h3C, "mr.d1");
    @(negedge clk);
    rst = 1'b1;
    bus.dataReady_i = 1'b1;
    bus.midiData_i  = 8'h64;
    model_reset();
    #1;
    check_outs("mr.async");
    @(posedge clk);
    #1;
    check_outs("mr.held");
    @(negedge clk);
    bus.dataReady_i = 1'b0;
    rst = 1'b0;
    send(8'h64, "mr.discard");
    idle(1, "mr.after");

    // Random stream
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 19);
      if (r < 12)
        b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(8'h3C + $urandom_range(0, 3));
      else if (r < 18)
        b = st_tab[$urandom_range(0, 11)];
      else
        b = 8'($urandom_range(0, 255));
      send(b, "rnd");
      if ($urandom_range(0, 15) == 0) idle(1, "rnd.gap");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
